keypad_scanner: RTL and testbench

- Input-side counterpart of the 7-segment display driver: it reads a 4x4 matrix hex keypad instead of writing digits.
- Drives one keypad row low at a time and samples the four column lines.
- Debounces both press and release, then emits a 4-bit hex key code plus a one-cycle strobe.
- The key code feeds the display driver's 4-bit digit input and the rest of the project's control logic.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/scan_tick_gen.sv | 19 +
 rtl/keypad_scanner.sv | 120 ++++++++++++
 tb/tb_keypad_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 hex keypad scanner: FSM encodings, key map and
// the column decode helper.
package keypad_pkg;

   localparam int NUM_ROWS = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_SCAN     = 2'd0;
   localparam state_t ST_DEBOUNCE = 2'd1;
   localparam state_t ST_PRESSED  = 2'd2;
   localparam state_t ST_RELEASE  = 2'd3;

   // Nibble {row_idx, col_idx} holds the hex code printed on that key.
   localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } col_hit_t;

   // Exactly one low column is a key; none or several low is ghosting.
   function automatic col_hit_t decode_col(input logic [3:0] c);
      col_hit_t r;
      r.hit = 1'b0;
      r.idx = 2'd0;
      case (c)
         4'b1110: begin r.hit = 1'b1; r.idx = 2'd0; end
         4'b1101: begin r.hit = 1'b1; r.idx = 2'd1; end
         4'b1011: begin r.hit = 1'b1; r.idx = 2'd2; end
         4'b0111: begin r.hit = 1'b1; r.idx = 2'd3; end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider; tick is high for one clk each time the counter wraps.
module scan_tick_gen #(
   parameter int SCAN_DIV_BITS = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [SCAN_DIV_BITS-1:0] div;

   always_ff @(posedge clk) begin
      if (rst) div <= '0;
      else     div <= div + SCAN_DIV_BITS'(1);
   end

   assign tick = &div;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row, debounces press and
// release of a single column hit, and reports the hex code with a strobe.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_BITS  = 16,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [4:0] DB_LIM = 5'(DEBOUNCE_TICKS);

   logic [3:0] col_m, col_s;
   logic       tick;
   state_t     state;
   logic [1:0] row_idx, cap_col;
   logic [3:0] cap_pat, cnt;
   logic [4:0] cnt_nxt;
   logic       cnt_done;
   col_hit_t   hit;

   scan_tick_gen #(.SCAN_DIV_BITS(SCAN_DIV_BITS)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Columns idle high, so the synchronizer resets to the no-key pattern.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_m <= 4'hF;
         col_s <= 4'hF;
      end else begin
         col_m <= col;
         col_s <= col_m;
      end
   end

   assign hit      = decode_col(col_s);
   assign cnt_nxt  = {1'b0, cnt} + 5'd1;
   assign cnt_done = cnt_nxt >= DB_LIM;
   assign row      = ~(4'b0001 << row_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_SCAN;
         row_idx   <= 2'd0;
         cap_col   <= 2'd0;
         cap_pat   <= 4'hF;
         cnt       <= 4'd0;
         key       <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (tick) begin
            case (state)
               ST_SCAN: begin
                  if (hit.hit) begin
                     cap_col <= hit.idx;
                     cap_pat <= col_s;
                     cnt     <= 4'd1;
                     state   <= ST_DEBOUNCE;
                  end else begin
                     row_idx <= row_idx + 2'd1;
                  end
               end
               ST_DEBOUNCE: begin
                  if (col_s == cap_pat) begin
                     if (cnt_done) begin
                        state     <= ST_PRESSED;
                        key       <= KEY_MAP[{row_idx, cap_col}];
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt       <= 4'd0;
                     end else begin
                        cnt <= cnt_nxt[3:0];
                     end
                  end else begin
                     state   <= ST_SCAN;
                     row_idx <= row_idx + 2'd1;
                     cnt     <= 4'd0;
                  end
               end
               ST_PRESSED: begin
                  if (col_s == 4'hF) begin
                     state <= ST_RELEASE;
                     cnt   <= 4'd1;
                  end
               end
               ST_RELEASE: begin
                  if (col_s == 4'hF) begin
                     if (cnt_done) begin
                        state    <= ST_SCAN;
                        key_held <= 1'b0;
                        row_idx  <= row_idx + 2'd1;
                        cnt      <= 4'd0;
                     end else begin
                        cnt <= cnt_nxt[3:0];
                     end
                  end else if (!col_s[cap_col]) begin
                     // Bounce back onto the same key: resume holding, no new strobe.
                     state <= ST_PRESSED;
                     cnt   <= 4'd0;
                  end
               end
               default: state <= ST_SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a fast scan tick and a simple key
// matrix model that pulls a column low while its key's row is driven low.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row, col, key;
   logic        key_valid, key_held;
   logic [15:0] pressed = '0;

   int   total = 0;
   int   bad = 0;
   int   npulse = 0;
   int   wide = 0;
   logic kv_q = 1'b0;

   keypad_scanner #(.SCAN_DIV_BITS(2), .DEBOUNCE_TICKS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid) npulse <= npulse + 1;
      if (key_valid && kv_q) wide <= wide + 1;
      kv_q <= key_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_held(input logic lvl, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (key_held === lvl) begin ok = 1'b1; break; end
      end
   endtask

   // Returns at the first negedge of a fresh dwell on row pattern r.
   task automatic wait_row(input logic [3:0] r, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (row !== r) break;
      end
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (row === r) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      bit         ok, held_ok;
      int         base;
      logic [3:0] exp_row, seen;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_row", row, 4'hE);
      chk("rst_key", key, 4'h0);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_held", key_held, 1'b0);
      rst = 1'b0;

      // Idle scan: row steps every 4 clk starting with 1110.
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         chk("idle_row", row, exp_row);
      end
      chk("idle_key", key, 4'h0);
      chk("idle_pulses", npulse, 0);

      // Steady press of r1,c1 -> '5'.
      base = npulse;
      pressed[5] = 1'b1;
      wait_held(1'b1, 200, ok);
      chk("t2_accept", ok, 1);
      repeat (40) @(negedge clk);
      chk("t2_pulses", npulse - base, 1);
      chk("t2_key", key, 4'h5);
      chk("t2_held", key_held, 1'b1);
      pressed = '0;
      wait_held(1'b0, 200, ok);
      chk("t2_release", ok, 1);
      chk("t2_key_kept", key, 4'h5);
      repeat (2) @(negedge clk);
      chk("t2_pulses_after", npulse - base, 1);

      // Short press of r3,c1 for two ticks: never accepted, scanning resumes.
      base = npulse;
      wait_row(4'b0111, 100, ok);
      chk("t3_row3", ok, 1);
      pressed[13] = 1'b1;
      repeat (8) @(negedge clk);
      pressed = '0;
      seen = 4'h0;
      repeat (60) begin
         @(negedge clk);
         seen = seen | ~row;
      end
      chk("t3_pulses", npulse - base, 0);
      chk("t3_held", key_held, 1'b0);
      chk("t3_rows_resume", seen, 4'hF);

      // Two keys on one row are ghosted; dropping one leaves a clean '1'.
      base = npulse;
      pressed[0] = 1'b1;
      pressed[3] = 1'b1;
      repeat (80) @(negedge clk);
      chk("t4_ghost_pulses", npulse - base, 0);
      chk("t4_ghost_held", key_held, 1'b0);
      pressed[3] = 1'b0;
      wait_held(1'b1, 200, ok);
      chk("t4_accept", ok, 1);
      repeat (4) @(negedge clk);
      chk("t4_pulses", npulse - base, 1);
      chk("t4_key", key, 4'h1);
      pressed = '0;
      wait_held(1'b0, 200, ok);
      chk("t4_release", ok, 1);

      // 'D' held, one-tick release glitch, held again.
      base = npulse;
      pressed[15] = 1'b1;
      wait_held(1'b1, 200, ok);
      chk("t5_accept", ok, 1);
      repeat (8) @(negedge clk);
      held_ok = 1'b1;
      pressed[15] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (key_held !== 1'b1) held_ok = 1'b0;
      end
      pressed[15] = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (key_held !== 1'b1) held_ok = 1'b0;
      end
      chk("t5_held_through", held_ok, 1);
      chk("t5_pulses", npulse - base, 1);
      chk("t5_key", key, 4'hD);
      pressed = '0;
      wait_held(1'b0, 200, ok);
      chk("t5_release", ok, 1);

      // Reset while debouncing r2,c0 with cnt=3.
      base = npulse;
      wait_row(4'b1011, 100, ok);
      chk("t6_row2", ok, 1);
      pressed[8] = 1'b1;
      repeat (12) @(negedge clk);
      chk("t6_no_pulse_yet", npulse - base, 0);
      chk("t6_not_held", key_held, 1'b0);
      rst = 1'b1;
      pressed = '0;
      @(negedge clk);
      chk("t6_rst_row", row, 4'hE);
      chk("t6_rst_held", key_held, 1'b0);
      chk("t6_rst_valid", key_valid, 1'b0);
      chk("t6_rst_key", key, 4'h0);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("t6_no_pulse_after", npulse - base, 0);
      chk("t6_held_after", key_held, 1'b0);

      chk("strobe_width", wide, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
